// File: rtl/image_scale_pkg.sv
// Shared constants, state encoding and step computation for the bilinear scaling sequencer.
package image_scale_pkg;

  localparam int FRAC_BITS = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    CAP  = 3'd5,
    OUT  = 3'd6,
    DONE = 3'd7
  } state_e;

  // 16.16 source increment per destination pixel, truncated.
  function automatic logic [31:0] calc_step(input int src, input int dst);
    logic [63:0] num;
    num = 64'(src) << FRAC_BITS;
    return 32'(num / 64'(dst));
  endfunction

endpackage

// File: rtl/image_scale_coord_gen.sv
// Destination raster walker: output coordinates, 16.16 source accumulators,
// clamped neighbour columns/rows and the last-pixel flag.
module image_scale_coord_gen
  import image_scale_pkg::*;
#(
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480,
  parameter int DST_WIDTH  = 1280,
  parameter int DST_HEIGHT = 960
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_clear,
  input  logic        advance,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic [15:0] x0,
  output logic [15:0] x1,
  output logic [15:0] y0,
  output logic [15:0] y1,
  output logic [15:0] x0_nxt,
  output logic [15:0] y0_nxt,
  output logic [15:0] x_frac,
  output logic [15:0] y_frac,
  output logic        last_pix
);

  localparam logic [31:0] STEP_X  = calc_step(SRC_WIDTH, DST_WIDTH);
  localparam logic [31:0] STEP_Y  = calc_step(SRC_HEIGHT, DST_HEIGHT);
  localparam logic [15:0] X_MAX   = 16'(SRC_WIDTH - 1);
  localparam logic [15:0] Y_MAX   = 16'(SRC_HEIGHT - 1);
  localparam logic [15:0] DX_LAST = 16'(DST_WIDTH - 1);
  localparam logic [15:0] DY_LAST = 16'(DST_HEIGHT - 1);

  function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  logic [15:0] out_x_q, out_x_d;
  logic [15:0] out_y_q, out_y_d;
  logic [31:0] sx_acc_q, sx_acc_d;
  logic [31:0] sy_acc_q, sy_acc_d;

  // Next raster position: clear at frame start, step on each accepted quad.
  always_comb begin
    out_x_d  = out_x_q;
    out_y_d  = out_y_q;
    sx_acc_d = sx_acc_q;
    sy_acc_d = sy_acc_q;
    if (frame_clear) begin
      out_x_d  = 16'd0;
      out_y_d  = 16'd0;
      sx_acc_d = 32'd0;
      sy_acc_d = 32'd0;
    end else if (advance) begin
      if (out_x_q < DX_LAST) begin
        out_x_d  = out_x_q + 16'd1;
        sx_acc_d = sx_acc_q + STEP_X;
      end else begin
        out_x_d  = 16'd0;
        sx_acc_d = 32'd0;
        out_y_d  = out_y_q + 16'd1;
        sy_acc_d = sy_acc_q + STEP_Y;
      end
    end else begin
      out_x_d  = out_x_q;
      sx_acc_d = sx_acc_q;
    end
  end

  // Raster position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_x_q  <= 16'd0;
      out_y_q  <= 16'd0;
      sx_acc_q <= 32'd0;
      sy_acc_q <= 32'd0;
    end else begin
      out_x_q  <= out_x_d;
      out_y_q  <= out_y_d;
      sx_acc_q <= sx_acc_d;
      sy_acc_q <= sy_acc_d;
    end
  end

  // x0_nxt/y0_nxt let the sequencer register the first read address of the upcoming pixel.
  assign x0       = clamp(sx_acc_q[31:16], X_MAX);
  assign y0       = clamp(sy_acc_q[31:16], Y_MAX);
  assign x1       = clamp(x0 + 16'd1, X_MAX);
  assign y1       = clamp(y0 + 16'd1, Y_MAX);
  assign x0_nxt   = clamp(sx_acc_d[31:16], X_MAX);
  assign y0_nxt   = clamp(sy_acc_d[31:16], Y_MAX);
  assign x_frac   = sx_acc_q[15:0];
  assign y_frac   = sy_acc_q[15:0];
  assign out_x    = out_x_q;
  assign out_y    = out_y_q;
  assign last_pix = (out_x_q == DX_LAST) && (out_y_q == DY_LAST);

endmodule

// File: rtl/image_scale_ctrl.sv
// Bilinear scaling sequencer: fetches the four source neighbours of each destination
// pixel from a single-port frame memory and hands them to the interpolator.
module image_scale_ctrl
  import image_scale_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480,
  parameter int DST_WIDTH  = 1280,
  parameter int DST_HEIGHT = 960,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [4*DATA_WIDTH-1:0] pix_quad,
  output logic [15:0]             x_frac,
  output logic [15:0]             y_frac,
  output logic [15:0]             out_x,
  output logic [15:0]             out_y,
  output logic                    pix_last
);

  localparam logic [31:0] SRC_W32 = 32'(SRC_WIDTH);
  localparam int          DW      = DATA_WIDTH;

  function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] lin;
    lin = 32'(y) * SRC_W32 + 32'(x);
    return lin[ADDR_WIDTH-1:0];
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [4*DW-1:0]         pix_quad_q, pix_quad_d;
  logic                    mem_rd_en_q, mem_rd_en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pix_valid_q, pix_valid_d;
  logic                    pix_last_q, pix_last_d;
  logic                    frame_clear_s, advance_s, last_pix_s;
  logic [15:0]             x0_s, x1_s, y0_s, y1_s, x0_nxt_s, y0_nxt_s;

  image_scale_coord_gen #(
    .SRC_WIDTH  (SRC_WIDTH),
    .SRC_HEIGHT (SRC_HEIGHT),
    .DST_WIDTH  (DST_WIDTH),
    .DST_HEIGHT (DST_HEIGHT)
  ) u_coord (
    .clk         (clk),
    .rst         (rst),
    .frame_clear (frame_clear_s),
    .advance     (advance_s),
    .out_x       (out_x),
    .out_y       (out_y),
    .x0          (x0_s),
    .x1          (x1_s),
    .y0          (y0_s),
    .y1          (y1_s),
    .x0_nxt      (x0_nxt_s),
    .y0_nxt      (y0_nxt_s),
    .x_frac      (x_frac),
    .y_frac      (y_frac),
    .last_pix    (last_pix_s)
  );

  // Sequencer next state; each read address is registered on entry to the state that issues it.
  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    pix_quad_d    = pix_quad_q;
    frame_clear_s = 1'b0;
    advance_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          frame_clear_s = 1'b1;
          state_d       = RD0;
          mem_addr_d    = pix_addr(x0_nxt_s, y0_nxt_s);
        end else begin
          state_d = IDLE;
        end
      end
      RD0: begin
        state_d    = RD1;
        mem_addr_d = pix_addr(x1_s, y0_s);
      end
      RD1: begin
        pix_quad_d[DW-1:0] = mem_rd_data;
        state_d            = RD2;
        mem_addr_d         = pix_addr(x0_s, y1_s);
      end
      RD2: begin
        pix_quad_d[2*DW-1:DW] = mem_rd_data;
        state_d               = RD3;
        mem_addr_d            = pix_addr(x1_s, y1_s);
      end
      RD3: begin
        pix_quad_d[3*DW-1:2*DW] = mem_rd_data;
        state_d                 = CAP;
      end
      CAP: begin
        pix_quad_d[4*DW-1:3*DW] = mem_rd_data;
        state_d                 = OUT;
      end
      OUT: begin
        if (pix_ready) begin
          if (last_pix_s) begin
            state_d = DONE;
          end else begin
            advance_s  = 1'b1;
            state_d    = RD0;
            mem_addr_d = pix_addr(x0_nxt_s, y0_nxt_s);
          end
        end else begin
          state_d = OUT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they register alongside it.
  always_comb begin
    mem_rd_en_d = (state_d == RD0) || (state_d == RD1) || (state_d == RD2) || (state_d == RD3);
    busy_d      = (state_d != IDLE) && (state_d != DONE);
    pix_valid_d = (state_d == OUT);
    pix_last_d  = (state_d == OUT) && last_pix_s;
    done_d      = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      pix_quad_q  <= '0;
      mem_rd_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      pix_quad_q  <= pix_quad_d;
      mem_rd_en_q <= mem_rd_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign pix_quad  = pix_quad_q;
  assign mem_rd_en = mem_rd_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_valid = pix_valid_q;
  assign pix_last  = pix_last_q;

endmodule
